// File: rtl/uart_pkg.sv
// uart_pkg: values shared by the UART transmitter and receiver.
//   uart_state_t : receiver/transmitter state encoding
//   CNT_DEFAULT  : bit-period counter terminal value (one bit = CNT+1 clocks)
//   CNT_WIDTH    : width of the bit-period counter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int unsigned CNT_DEFAULT = 1250;
  localparam int          CNT_WIDTH   = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line into the clk domain and
// flags a high-to-low transition of the synchronized line.
//   clk       : system clock
//   rst       : asynchronous active-low reset (all flops reset to line-idle 1)
//   rx_serial : raw asynchronous serial input
//   rx_s      : synchronized line (two flops behind the pin)
//   fall      : high for one cycle when rx_s has just gone from 1 to 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_serial,
  output logic rx_s,
  output logic fall
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Resetting to 1 means a line that is already low when reset releases
  // never produces a fall; a fresh 1->0 transition is required.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx_serial;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rx_s = sync2_reg;
  assign fall = prev_reg & ~sync2_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
//   Parameters:
//     CNT  : bit-period counter terminal value (bit = CNT+1 clocks)
//     HALF : counter value at which the start bit is re-checked
//   Ports:
//     clk         : system clock
//     rst         : asynchronous active-low reset
//     i_Rx_serial : asynchronous serial line
//     o_data      : last correctly received byte, held until the next good one
//     o_valid     : one-cycle pulse when o_data updates
//     o_frame_err : one-cycle pulse when the stop bit is sampled low
//     o_busy      : high whenever a frame is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CNT  = CNT_DEFAULT,
  parameter int unsigned HALF = CNT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_Rx_serial,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_TERM  = CNT_WIDTH'(CNT);
  localparam logic [CNT_WIDTH-1:0] HALF_TERM = CNT_WIDTH'(HALF);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(i_Rx_serial),
    .rx_s     (rx_s),
    .fall     (fall)
  );

  uart_state_t          state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg,   cnt_next;
  logic [2:0]           idx_reg,   idx_next;
  logic [7:0]           shift_reg, shift_next;
  logic [7:0]           data_reg,  data_next;
  logic                 valid_reg, valid_next;
  logic                 err_reg,   err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        // A line held low (break) gives no fall, so no retrigger.
        if (fall) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt_reg == HALF_TERM) begin
          cnt_next = '0;
          // Line back high at mid-start means it was only a glitch.
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == CNT_TERM) begin
          // Started at mid-start-bit, so every terminal count is mid-bit.
          cnt_next            = '0;
          shift_next[idx_reg] = rx_s;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (cnt_reg == CNT_TERM) begin
          // Leaving at mid-stop-bit leaves half a bit to catch the next start.
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_frame_err = err_reg;
  assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed frames against a cycle-level timing model of the
// receiver, plus literal expectations for strobe timing and received bytes.
module tb_uart_rx;

  localparam int CNT  = 124;
  localparam int HALF = CNT / 2;
  localparam int BIT  = CNT + 1;
  // Pin fall to strobe: 2 sync cycles + HALF + 9*(CNT+1) + 2 = 1191 for CNT=124.
  localparam int STROBE_LAT = 1191;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_rx #(.CNT(CNT), .HALF(HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_Rx_serial(rx_pin),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- timing model ----------------
  // Works from the pin history and the frame timing formulas relative to the
  // detect cycle t0, not from any counter or state encoding.
  bit       h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;   // pin 1, 2, 3 cycles ago
  bit       m_active = 1'b0;
  int       m_t0 = 0;
  bit [7:0] m_bits = 8'h00;
  bit [7:0] m_data = 8'h00;
  bit       pend_valid = 1'b0, pend_err = 1'b0;
  int       m_strobe_cyc = -1;
  bit       e_busy, e_valid, e_err;
  bit [7:0] e_data;
  int       rel, k;

  always @(negedge clk) begin
    if (!rst) begin
      m_active = 1'b0; pend_valid = 1'b0; pend_err = 1'b0; m_data = 8'h00;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    end
    e_busy = m_active; e_valid = pend_valid; e_err = pend_err; e_data = m_data;
    check("cyc_busy",  32'(o_busy),      32'(e_busy));
    check("cyc_valid", 32'(o_valid),     32'(e_valid));
    check("cyc_ferr",  32'(o_frame_err), 32'(e_err));
    check("cyc_data",  32'(o_data),      32'(e_data));
    if (rst) begin
      pend_valid = 1'b0; pend_err = 1'b0;
      if (m_active) begin
        rel = cyc - m_t0;
        if (rel == HALF + 1) begin
          if (h2) m_active = 1'b0;        // false start
        end else if (rel >= HALF + 2 + CNT && ((rel - (HALF + 2 + CNT)) % BIT) == 0) begin
          k = (rel - (HALF + 2 + CNT)) / BIT;
          if (k < 8) begin
            m_bits[k] = h2;
          end else begin
            m_active = 1'b0;
            m_strobe_cyc = cyc + 1;
            if (h2) begin m_data = m_bits; pend_valid = 1'b1; end
            else pend_err = 1'b1;
          end
        end
      end else if (h3 && !h2) begin
        m_active = 1'b1;
        m_t0 = cyc;
      end
      h3 = h2; h2 = h1; h1 = rx_pin;
    end
  end

  // ---------------- output monitor ----------------
  int       vq_cyc[$];
  logic [7:0] vq_data[$];
  int       err_cnt = 0, busy_cnt = 0, last_err_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      if (o_valid === 1'b1) begin vq_cyc.push_back(cyc); vq_data.push_back(o_data); end
      if (o_frame_err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
      if (o_busy === 1'b1) busy_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int k0);
    k0 = cyc;
    rx_pin = 1'b0;
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      hold(BIT);
    end
    rx_pin = stop_bit;
    hold(BIT);
  endtask

  task automatic pop_valid(input string name, input logic [7:0] exp, output int vc);
    logic [7:0] d;
    check({name, "_present"}, 32'(vq_cyc.size() > 0), 32'd1);
    vc = -1;
    if (vq_cyc.size() > 0) begin
      vc = vq_cyc.pop_front();
      d  = vq_data.pop_front();
      check({name, "_data"}, 32'(d), 32'(exp));
    end
  endtask

  logic [7:0] lb [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
  logic       tx_done = 1'b0;
  int         tx_done_cnt = 0;
  always @(posedge clk) if (tx_done) tx_done_cnt++;

  initial begin
    int k0, k1, vc0, vc1, eb, bb, vn;
    logic [7:0] c3;
    rst = 1'b0; rx_pin = 1'b1;
    hold(5);
    check("reset_data",  32'(o_data), 32'h00);
    check("reset_busy",  32'(o_busy), 32'd0);
    rst = 1'b1;
    hold(20);

    // Single frame 0xA5
    eb = err_cnt;
    send_byte(8'hA5, 1'b1, k0);
    hold(20);
    check("a5_count", 32'(vq_cyc.size()), 32'd1);
    pop_valid("a5", 8'hA5, vc0);
    check("a5_latency", 32'(vc0 - k0), 32'(STROBE_LAT));
    check("a5_model_latency", 32'(m_strobe_cyc - k0), 32'(STROBE_LAT));
    check("a5_no_ferr", 32'(err_cnt - eb), 32'd0);
    $display("frame A5: strobe at +%0d, data 0x%0h", vc0 - k0, o_data);

    // Back-to-back 0x00 then 0xFF
    send_byte(8'h00, 1'b1, k0);
    send_byte(8'hFF, 1'b1, k1);
    hold(20);
    pop_valid("b2b_first", 8'h00, vc0);
    pop_valid("b2b_second", 8'hFF, vc1);
    check("b2b_spacing", 32'(vc1 - vc0), 32'(10 * BIT));
    $display("frames 00/FF back-to-back: spacing %0d", vc1 - vc0);

    // 30-cycle glitch, shorter than HALF
    bb = busy_cnt; eb = err_cnt; vn = vq_cyc.size();
    rx_pin = 1'b0; hold(30);
    rx_pin = 1'b1; hold(200);
    check("glitch_busy_cycles", 32'(busy_cnt - bb), 32'(HALF + 1));
    check("glitch_no_valid", 32'(vq_cyc.size() - vn), 32'd0);
    check("glitch_no_ferr", 32'(err_cnt - eb), 32'd0);
    send_byte(8'h3C, 1'b1, k0);
    hold(20);
    pop_valid("after_glitch", 8'h3C, vc0);
    $display("glitch: busy %0d cycles, then 0x3C received", busy_cnt - bb);

    // 0x5A with stop bit low, then break
    eb = err_cnt; vn = vq_cyc.size();
    send_byte(8'h5A, 1'b0, k0);
    bb = busy_cnt;
    hold(3 * BIT);
    check("ferr_count", 32'(err_cnt - eb), 32'd1);
    check("ferr_latency", 32'(last_err_cyc - k0), 32'(STROBE_LAT));
    check("ferr_no_valid", 32'(vq_cyc.size() - vn), 32'd0);
    check("ferr_data_kept", 32'(o_data), 32'h3C);
    check("break_no_busy", 32'(busy_cnt - bb), 32'd0);
    rx_pin = 1'b1; hold(200);
    send_byte(8'h96, 1'b1, k0);
    hold(20);
    pop_valid("after_break", 8'h96, vc0);
    $display("frame 5A with bad stop: frame error, data held; 0x96 after break");

    // Reset during bit 4 of 0xC3
    eb = err_cnt; vn = vq_cyc.size();
    c3 = 8'hC3;
    rx_pin = 1'b0; hold(BIT);
    for (int i = 0; i < 4; i++) begin rx_pin = c3[i]; hold(BIT); end
    rx_pin = c3[4]; hold(60);
    rst = 1'b0;
    hold(5);
    check("rst_mid_data",  32'(o_data), 32'h00);
    check("rst_mid_busy",  32'(o_busy), 32'd0);
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    check("rst_mid_ferr",  32'(o_frame_err), 32'd0);
    rx_pin = 1'b1;
    rst = 1'b1;
    hold(200);
    check("rst_no_valid", 32'(vq_cyc.size() - vn), 32'd0);
    check("rst_no_ferr", 32'(err_cnt - eb), 32'd0);
    send_byte(8'h81, 1'b1, k0);
    hold(20);
    pop_valid("after_reset", 8'h81, vc0);
    $display("reset mid-frame: aborted, then 0x81 received");

    // Transmitter-style loopback
    eb = err_cnt; vn = vq_cyc.size(); tx_done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(lb[i], 1'b1, k0);
      tx_done = 1'b1; hold(1); tx_done = 1'b0;
    end
    hold(20);
    check("loop_done_vs_valid", 32'(vq_cyc.size() - vn), 32'(tx_done_cnt));
    for (int i = 0; i < 4; i++) begin
      pop_valid("loop_byte", lb[i], vc0);
      $display("loopback byte %0d: expected 0x%0h", i, lb[i]);
    end
    check("loop_no_ferr", 32'(err_cnt - eb), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
